// File: rtl/serial_bus_master_port.sv
// Master endpoint of the single-wire serial bus: serialises start/ID/address,
// runs the write or read data phase against slave handshakes, aborts on timeout.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | line released, waiting for req
// START      | driving the two-cycle 0 start pattern
// SID        | driving slave_id MSB-first
// ADDR       | driving addr MSB-first
// ADDR_ACK   | line released, waiting for 0 on two consecutive cycles
// WR_SYNC    | driving 1 then the 0 data start bit
// WR_DATA    | driving wdata MSB-first
// WR_BUSY    | waiting for slave_busy to rise and then fall
// WR_ACK     | waiting for line 0 followed by line 1
// RD_BUSY    | waiting for slave_busy to rise and then fall
// RD_DATA    | shifting in read data MSB-first
// FINISH     | done pulse, bus handed back
// ABORT      | timeout_err pulse, bus handed back
module serial_bus_master_port #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int TIMEOUT       = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic                     rd_wrt,
   input  logic [2:0]               slave_id,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     done,
   output logic                     timeout_err,
   output logic                     busy,
   output logic                     bus_util,
   output logic                     bus_rd_wrt,
   inout  wire                      data_bus_serial,
   input  logic                     slave_busy
);

   localparam int MAXW = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
   localparam int CW   = $clog2(MAXW + 1);
   localparam int WW   = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_SID, S_ADDR, S_ADDR_ACK, S_WR_SYNC, S_WR_DATA,
      S_WR_BUSY, S_WR_ACK, S_RD_BUSY, S_RD_DATA, S_FINISH, S_ABORT
   } state_t;

   state_t                   state;
   logic                     drv_en;
   logic                     drv_val;
   logic                     line;
   logic                     seen;
   logic                     wr_q;
   logic [2:0]               sid_sh;
   logic [ADDRESS_WIDTH-1:0] addr_sh;
   logic [DATA_WIDTH-1:0]    wdata_sh;
   logic [DATA_WIDTH-1:0]    rx_sh;
   logic [CW-1:0]            bit_cnt;
   logic [WW-1:0]            wait_cnt;
   logic                     wait_expired;

   assign data_bus_serial = drv_en ? drv_val : 1'bz;
   assign line            = data_bus_serial;
   assign wait_expired    = (wait_cnt == WAIT_LAST);

   // seen doubles as the first-half flag of every two-step wait condition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         drv_en      <= 1'b0;
         drv_val     <= 1'b0;
         seen        <= 1'b0;
         wr_q        <= 1'b0;
         sid_sh      <= '0;
         addr_sh     <= '0;
         wdata_sh    <= '0;
         rx_sh       <= '0;
         bit_cnt     <= '0;
         wait_cnt    <= '0;
         rdata       <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         bus_util    <= 1'b0;
         bus_rd_wrt  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  wr_q       <= rd_wrt;
                  sid_sh     <= slave_id;
                  addr_sh    <= addr;
                  wdata_sh   <= wdata;
                  bus_util   <= 1'b1;
                  busy       <= 1'b1;
                  bus_rd_wrt <= rd_wrt;
                  drv_en     <= 1'b1;
                  drv_val    <= 1'b0;
                  bit_cnt    <= CW'(1);
                  state      <= S_START;
               end
            end

            S_START: begin
               if (bit_cnt == '0) begin
                  drv_val <= sid_sh[2];
                  sid_sh  <= {sid_sh[1:0], 1'b0};
                  bit_cnt <= CW'(2);
                  state   <= S_SID;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end

            S_SID: begin
               if (bit_cnt == '0) begin
                  drv_val <= addr_sh[ADDRESS_WIDTH-1];
                  addr_sh <= {addr_sh[ADDRESS_WIDTH-2:0], 1'b0};
                  bit_cnt <= ADDR_LAST;
                  state   <= S_ADDR;
               end else begin
                  drv_val <= sid_sh[2];
                  sid_sh  <= {sid_sh[1:0], 1'b0};
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end

            S_ADDR: begin
               if (bit_cnt == '0) begin
                  drv_en   <= 1'b0;
                  wait_cnt <= '0;
                  seen     <= 1'b0;
                  state    <= S_ADDR_ACK;
               end else begin
                  drv_val <= addr_sh[ADDRESS_WIDTH-1];
                  addr_sh <= {addr_sh[ADDRESS_WIDTH-2:0], 1'b0};
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end

            S_ADDR_ACK: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (seen && !line) begin
                  seen     <= 1'b0;
                  wait_cnt <= '0;
                  if (wr_q) begin
                     drv_en  <= 1'b1;
                     drv_val <= 1'b1;
                     bit_cnt <= CW'(1);
                     state   <= S_WR_SYNC;
                  end else begin
                     state <= S_RD_BUSY;
                  end
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  state       <= S_ABORT;
               end else begin
                  seen <= !line;
               end
            end

            S_WR_SYNC: begin
               if (bit_cnt == '0) begin
                  drv_val  <= wdata_sh[DATA_WIDTH-1];
                  wdata_sh <= {wdata_sh[DATA_WIDTH-2:0], 1'b0};
                  bit_cnt  <= DATA_LAST;
                  state    <= S_WR_DATA;
               end else begin
                  drv_val <= 1'b0;
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end

            S_WR_DATA: begin
               if (bit_cnt == '0) begin
                  drv_en   <= 1'b0;
                  wait_cnt <= '0;
                  seen     <= 1'b0;
                  state    <= S_WR_BUSY;
               end else begin
                  drv_val  <= wdata_sh[DATA_WIDTH-1];
                  wdata_sh <= {wdata_sh[DATA_WIDTH-2:0], 1'b0};
                  bit_cnt  <= bit_cnt - 1'b1;
               end
            end

            S_WR_BUSY, S_RD_BUSY: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (seen && !slave_busy) begin
                  seen     <= 1'b0;
                  wait_cnt <= '0;
                  if (state == S_WR_BUSY) begin
                     state <= S_WR_ACK;
                  end else begin
                     bit_cnt <= DATA_LAST;
                     state   <= S_RD_DATA;
                  end
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  state       <= S_ABORT;
               end else if (slave_busy) begin
                  seen <= 1'b1;
               end
            end

            S_WR_ACK: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (seen && line) begin
                  done  <= 1'b1;
                  state <= S_FINISH;
               end else if (wait_expired) begin
                  timeout_err <= 1'b1;
                  state       <= S_ABORT;
               end else if (!line) begin
                  seen <= 1'b1;
               end
            end

            S_RD_DATA: begin
               rx_sh <= {rx_sh[DATA_WIDTH-2:0], line};
               if (bit_cnt == '0) begin
                  rdata <= {rx_sh[DATA_WIDTH-2:0], line};
                  done  <= 1'b1;
                  state <= S_FINISH;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end

            S_FINISH, S_ABORT: begin
               done        <= 1'b0;
               timeout_err <= 1'b0;
               busy        <= 1'b0;
               bus_util    <= 1'b0;
               bus_rd_wrt  <= 1'b0;
               drv_en      <= 1'b0;
               state       <= S_IDLE;
            end

            default: begin
               drv_en <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bus_master_port.sv
// Directed bench for serial_bus_master_port: a cycle-scripted slave model drives
// the bus while header bits and transaction results are checked from queues.
module tb_serial_bus_master_port;

   localparam int AW = 15;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          rd_wrt = 1'b0;
   logic [2:0]    slave_id = '0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          done, timeout_err, busy, bus_util, bus_rd_wrt;
   logic          slave_busy = 1'b0;
   logic          sl_en = 1'b0;
   logic          sl_val = 1'b0;
   wire           data_bus_serial;

   assign data_bus_serial = sl_en ? sl_val : 1'bz;
   pullup (data_bus_serial);

   serial_bus_master_port dut (
      .clk             (clk),
      .rst             (rst),
      .req             (req),
      .rd_wrt          (rd_wrt),
      .slave_id        (slave_id),
      .addr            (addr),
      .wdata           (wdata),
      .rdata           (rdata),
      .done            (done),
      .timeout_err     (timeout_err),
      .busy            (busy),
      .bus_util        (bus_util),
      .bus_rd_wrt      (bus_rd_wrt),
      .data_bus_serial (data_bus_serial),
      .slave_busy      (slave_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          is_to;
      logic [DW-1:0] rd;
      int            at;
   } exp_t;

   exp_t sb[$];
   logic exp_bits[$];
   int   t0 = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;
   logic cur_rw = 1'b0;
   logic util_ok = 1'b1;
   logic rw_ok = 1'b1;
   logic quiet_ok = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic tick();
      util_ok = util_ok & (bus_util === 1'b1);
      rw_ok   = rw_ok & (bus_rd_wrt === cur_rw);
      step();
   endtask

   task automatic begin_txn(input logic rw, input logic [2:0] id, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic is_to,
                            input logic [DW-1:0] rd, input int at);
      exp_t e;
      t0      = cyc - 1;
      cur_rw  = rw;
      util_ok = 1'b1;
      rw_ok   = 1'b1;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      exp_bits.push_back(1'b0);
      for (int i = 2; i >= 0; i--) exp_bits.push_back(id[i]);
      for (int i = AW - 1; i >= 0; i--) exp_bits.push_back(a[i]);
      if (rw) begin
         exp_bits.push_back(1'b1);
         exp_bits.push_back(1'b0);
         for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(wd[i]);
      end
      e.is_to = is_to;
      e.rd    = rd;
      e.at    = at;
      sb.push_back(e);
   endtask

   task automatic issue(input logic rw, input logic [2:0] id, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic hold, input logic is_to,
                        input logic [DW-1:0] rd, input int at);
      rd_wrt   = rw;
      slave_id = id;
      addr     = a;
      wdata    = wd;
      req      = 1'b1;
      step();
      if (!hold) req = 1'b0;
      begin_txn(rw, id, a, wd, is_to, rd, at);
   endtask

   task automatic check_bits(input int n, input string tag);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = exp_bits.pop_front();
         chk($sformatf("%s bit %0d", tag, i), 32'(data_bus_serial), 32'(b));
         tick();
      end
   endtask

   task automatic slave_ack();
      chk("line released for ack", 32'(data_bus_serial), 32'd1);
      sl_en  = 1'b1;
      sl_val = 1'b0;
      tick();
      tick();
      sl_en = 1'b0;
   endtask

   task automatic write_tail();
      chk("line released after wdata", 32'(data_bus_serial), 32'd1);
      slave_busy = 1'b1;
      tick();
      slave_busy = 1'b0;
      tick();
      sl_en  = 1'b1;
      sl_val = 1'b0;
      tick();
      sl_en = 1'b0;
      tick();
   endtask

   task automatic slave_read(input int nbusy, input logic [DW-1:0] d);
      slave_busy = 1'b1;
      repeat (nbusy) tick();
      slave_busy = 1'b0;
      tick();
      for (int i = DW - 1; i >= 0; i--) begin
         sl_en  = 1'b1;
         sl_val = d[i];
         tick();
      end
      sl_en = 1'b0;
   endtask

   task automatic wait_result(input int limit, input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (!(done === 1'b1 || timeout_err === 1'b1) && n < limit) begin
         tick();
         n++;
      end
      util_ok = util_ok & (bus_util === 1'b1);
      e = sb.pop_front();
      chk({tag, " result arrives"}, 32'(done | timeout_err), 32'd1);
      chk({tag, " timeout_err"}, 32'(timeout_err), 32'(e.is_to));
      chk({tag, " done"}, 32'(done), 32'(!e.is_to));
      chk({tag, " result cycle"}, 32'(cyc - t0), 32'(e.at));
      chk({tag, " rdata"}, 32'(rdata), 32'(e.rd));
      chk({tag, " busy with pulse"}, 32'(busy), 32'd1);
      chk({tag, " bus_util held"}, 32'(util_ok), 32'd1);
      chk({tag, " bus_rd_wrt held"}, 32'(rw_ok), 32'd1);
      step();
      chk({tag, " busy after"}, 32'(busy), 32'd0);
      chk({tag, " bus_util after"}, 32'(bus_util), 32'd0);
      chk({tag, " pulse cleared"}, 32'(done | timeout_err), 32'd0);
      chk({tag, " line released after"}, 32'(data_bus_serial), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      step();
      step();
      chk("reset rdata", 32'(rdata), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset timeout_err", 32'(timeout_err), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset bus_util", 32'(bus_util), 32'd0);
      chk("reset bus_rd_wrt", 32'(bus_rd_wrt), 32'd0);
      chk("reset line", 32'(data_bus_serial), 32'd1);
      rst = 1'b0;
      step();

      // write, zero slave delays
      issue(1'b1, 3'b010, 15'h1234, 8'hA5, 1'b0, 1'b0, 8'h00, 37);
      check_bits(AW + 5, "wr hdr");
      slave_ack();
      check_bits(DW + 2, "wr data");
      write_tail();
      wait_result(20, "write");

      // read with five busy cycles
      issue(1'b0, 3'b001, 15'h7FFF, 8'h00, 1'b0, 1'b0, 8'h3C, 37);
      check_bits(AW + 5, "rd hdr");
      slave_ack();
      slave_read(5, 8'h3C);
      wait_result(20, "read");

      // no address ack
      issue(1'b0, 3'b100, 15'h0F0F, 8'h00, 1'b0, 1'b1, 8'h3C, 276);
      check_bits(AW + 5, "noack hdr");
      chk("noack line released", 32'(data_bus_serial), 32'd1);
      wait_result(400, "noack");

      // req held through a write, then a back-to-back read
      issue(1'b1, 3'b011, 15'h5555, 8'h0F, 1'b1, 1'b0, 8'h3C, 37);
      check_bits(AW + 5, "b2b wr hdr");
      rd_wrt   = 1'b0;
      slave_id = 3'b110;
      addr     = 15'h0ABC;
      wdata    = 8'h00;
      slave_ack();
      check_bits(DW + 2, "b2b wr data");
      write_tail();
      wait_result(20, "b2b write");
      step();
      req = 1'b0;
      begin_txn(1'b0, 3'b110, 15'h0ABC, 8'h00, 1'b0, 8'h96, 33);
      check_bits(AW + 5, "b2b rd hdr");
      slave_ack();
      slave_read(1, 8'h96);
      wait_result(20, "b2b read");

      // slave_busy stuck high during a read
      issue(1'b0, 3'b111, 15'h0001, 8'h00, 1'b0, 1'b1, 8'h96, 278);
      check_bits(AW + 5, "stuck hdr");
      slave_ack();
      slave_busy = 1'b1;
      wait_result(400, "stuck busy");
      slave_busy = 1'b0;
      step();

      // asynchronous reset in the middle of the address phase
      issue(1'b1, 3'b010, 15'h2AAA, 8'h5A, 1'b0, 1'b0, 8'h00, 0);
      sb.delete();
      exp_bits.delete();
      repeat (10) step();
      chk("mid-addr bus_util", 32'(bus_util), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async rst bus_util", 32'(bus_util), 32'd0);
      chk("async rst line", 32'(data_bus_serial), 32'd1);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst rdata", 32'(rdata), 32'd0);
      chk("async rst bus_rd_wrt", 32'(bus_rd_wrt), 32'd0);
      chk("async rst pulses", 32'(done | timeout_err), 32'd0);
      step();
      rst = 1'b0;
      quiet_ok = 1'b1;
      repeat (30) begin
         step();
         quiet_ok = quiet_ok & (done === 1'b0) & (timeout_err === 1'b0) & (bus_util === 1'b0)
                    & (data_bus_serial === 1'b1);
      end
      chk("post-reset quiet", 32'(quiet_ok), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
